// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a WIDTH-bit pattern out MSB-first,
// repeating it a programmable number of times with idle gaps between frames.
module seq_pattern_gen #(
  parameter int                WIDTH           = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_PATTERN = 8'b1011_0010,
  parameter int                CNT_W           = 4,
  parameter int                GAP             = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_last,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pattern_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [IDX_W-1:0] bit_idx_d;
  logic [CNT_W-1:0] frames_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             dout_q;
  logic             dout_valid_q;
  logic             frame_last_q;
  logic             busy_q;
  logic             done_q;

  assign bit_idx_d = bit_idx_q - 1'b1;

  // frames_q holds the frames still to send, including the one in flight,
  // so the full CNT_W range is usable without wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pattern_q    <= DEFAULT_PATTERN;
      bit_idx_q    <= '0;
      frames_q     <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      frame_last_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) pattern_q <= pattern_in;
          if (start && !abort) begin
            state_q      <= S_SHIFT;
            frames_q     <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
            bit_idx_q    <= IDX_TOP;
            dout_q       <= load ? pattern_in[WIDTH-1] : pattern_q[WIDTH-1];
            dout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state_q      <= S_IDLE;
            bit_idx_q    <= '0;
            frames_q     <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (bit_idx_q != '0) begin
            bit_idx_q    <= bit_idx_d;
            dout_q       <= pattern_q[bit_idx_d];
            frame_last_q <= (bit_idx_d == '0);
          end else if (frames_q > CNT_W'(1)) begin
            frames_q <= frames_q - 1'b1;
            if (GAP > 0) begin
              state_q      <= S_GAP;
              gap_cnt_q    <= GAP_TOP;
              dout_q       <= 1'b0;
              dout_valid_q <= 1'b0;
            end else begin
              bit_idx_q <= IDX_TOP;
              dout_q    <= pattern_q[WIDTH-1];
            end
          end else begin
            state_q      <= S_IDLE;
            done_q       <= 1'b1;
            frames_q     <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        S_GAP: begin
          if (abort) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            frames_q  <= '0;
            busy_q    <= 1'b0;
          end else if (gap_cnt_q == '0) begin
            state_q      <= S_SHIFT;
            bit_idx_q    <= IDX_TOP;
            dout_q       <= pattern_q[WIDTH-1];
            dout_valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_last = frame_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: framing, repeats, gaps, ignored
// commands while busy, abort and mid-frame reset.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] pattern_in;
  logic       start;
  logic [3:0] repeat_n;
  logic       abort;
  logic       dout, dout_valid, frame_last, busy, done;
  logic [4:0] outs;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_GAP  = 5'b00010;
  localparam logic [4:0] O_DONE = 5'b00001;

  seq_pattern_gen #(
    .WIDTH(8), .DEFAULT_PATTERN(8'b1011_0010), .CNT_W(4), .GAP(2)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in),
    .start(start), .repeat_n(repeat_n), .abort(abort),
    .dout(dout), .dout_valid(dout_valid), .frame_last(frame_last),
    .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  assign outs = {dout, dout_valid, frame_last, busy, done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // outs packing: {dout, dout_valid, frame_last, busy, done}
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks one full frame starting at the current cycle; optionally pokes
  // start+load(0xFF) after checking bit index 'poke'.
  task automatic run_frame(input string tag, input logic [7:0] pat, input int poke);
    for (int i = 7; i >= 0; i--) begin
      chk(tag, outs, {pat[i], 1'b1, (i == 0), 1'b1, 1'b0});
      if (i == poke) begin
        start = 1'b1; load = 1'b1; pattern_in = 8'hFF;
      end else begin
        start = 1'b0; load = 1'b0;
      end
      tick();
    end
    start = 1'b0; load = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] n);
    start = 1'b1; repeat_n = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; pattern_in = 8'h00; start = 1'b0;
    repeat_n = 4'd0; abort = 1'b0;
    tick(); tick();
    chk("reset_outs", outs, O_IDLE);
    reset = 1'b0;
    tick();
    chk("idle_outs", outs, O_IDLE);

    // 1: default pattern, single frame
    do_start(4'd1);
    run_frame("t1_bit", 8'b1011_0010, -1);
    chk("t1_done", outs, O_DONE);
    tick();
    chk("t1_idle", outs, O_IDLE);

    // 2: load 0xA5, two frames with gap
    load = 1'b1; pattern_in = 8'hA5;
    tick();
    load = 1'b0;
    do_start(4'd2);
    run_frame("t2_f0", 8'hA5, -1);
    chk("t2_gap0", outs, O_GAP); tick();
    chk("t2_gap1", outs, O_GAP); tick();
    run_frame("t2_f1", 8'hA5, -1);
    chk("t2_done", outs, O_DONE); tick();
    chk("t2_idle", outs, O_IDLE);

    // 3: repeat_n=0 -> one frame; restart during the done cycle
    do_start(4'd0);
    run_frame("t3_f0", 8'hA5, -1);
    chk("t3_done", outs, O_DONE);
    do_start(4'd1);
    run_frame("t3_restart", 8'hA5, -1);
    chk("t3_done2", outs, O_DONE); tick();
    chk("t3_idle", outs, O_IDLE);

    // 4: start/load while busy are ignored
    do_start(4'd1);
    run_frame("t4_busy", 8'hA5, 5);
    chk("t4_done", outs, O_DONE); tick();
    chk("t4_idle", outs, O_IDLE);
    do_start(4'd1);
    run_frame("t4_kept", 8'hA5, -1);
    chk("t4_done2", outs, O_DONE); tick();

    // 5: abort on the 3rd bit, then abort+start in idle, then a clean frame
    do_start(4'd3);
    chk("t5_b7", outs, 5'b11010); tick();
    chk("t5_b6", outs, 5'b01010); tick();
    chk("t5_b5", outs, 5'b11010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort", outs, O_IDLE); tick();
    chk("t5_nodone", outs, O_IDLE);
    abort = 1'b1; start = 1'b1; repeat_n = 4'd1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("t5_abort_wins", outs, O_IDLE); tick();
    chk("t5_abort_wins2", outs, O_IDLE);
    do_start(4'd1);
    run_frame("t5_after", 8'hA5, -1);
    chk("t5_done", outs, O_DONE); tick();

    // abort during the gap
    do_start(4'd2);
    run_frame("t5g_f0", 8'hA5, -1);
    chk("t5g_gap", outs, O_GAP);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5g_abort", outs, O_IDLE); tick();
    chk("t5g_nodone", outs, O_IDLE);

    // 6: reset mid-frame restores the default pattern
    do_start(4'd1);
    chk("t6_b7", outs, 5'b11010); tick();
    chk("t6_b6", outs, 5'b01010);
    reset = 1'b1;
    tick();
    chk("t6_reset", outs, O_IDLE);
    reset = 1'b0;
    tick();
    chk("t6_idle", outs, O_IDLE);
    do_start(4'd1);
    run_frame("t6_default", 8'b1011_0010, -1);
    chk("t6_done", outs, O_DONE); tick();

    // maximum repeat count: 15 frames, no wrap
    do_start(4'd15);
    for (int f = 0; f < 15; f++) begin
      run_frame("max_frame", 8'b1011_0010, -1);
      if (f < 14) begin
        chk("max_gap0", outs, O_GAP); tick();
        chk("max_gap1", outs, O_GAP); tick();
      end
    end
    chk("max_done", outs, O_DONE); tick();
    chk("max_idle", outs, O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter: the source side of the team's serial sequence-detector interface.
- Shifts a WIDTH-bit pattern out MSB-first on a single-bit line, one bit per clock.
- Supports a configurable repeat count, idle gap cycles between frames, a loadable pattern and abort.
- Drives detector benches and on-chip serial links with known framed stimulus.

Parameters:
WIDTH, 8, pattern length in bits (≥2)
DEFAULT_PATTERN, 8'b1011_0010, pattern register value after reset
CNT_W, 4, width of repeat_n
GAP, 2, idle cycles inserted between consecutive frames (0 = back-to-back)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  write pattern_in into pattern register (honoured only when not busy)
pattern_in  input  WIDTH  new pattern value
start  input  1  begin transmission (honoured only when not busy)
repeat_n  input  CNT_W  number of frames, sampled with start; 0 treated as 1
abort  input  1  terminate transmission immediately
dout  output  1  serial data; 0 whenever dout_valid=0
dout_valid  output  1  dout carries a pattern bit this cycle
frame_last  output  1  high with bit 0 (last bit) of each frame
busy  output  1  transmission in progress (SHIFT or GAP)
done  output  1  one-cycle pulse after the final bit of the final frame

Behaviour:
- One clock domain. Reset is synchronous and active-high, named clk and reset.
- All outputs are registered.
- Reset (any state, including mid-frame): next edge gives state IDLE, pattern register = DEFAULT_PATTERN, and dout, dout_valid, frame_last, busy and done all 0. Frame and bit counters clear.
- States:
  - IDLE: outputs low. done may be high for exactly one cycle on entry from the last frame.
  - SHIFT: drive bits.
  - GAP: busy=1, dout_valid=0, dout=0.
- IDLE + load: pattern register <= pattern_in.
- IDLE + start:
  - Capture frames = max(repeat_n, 1).
  - Move to SHIFT. busy=1 and dout_valid=1 from the next cycle (latency 1).
  - The first bit is pattern[WIDTH-1].
- IDLE + load + start in the same cycle: the frame transmits pattern_in, which is also stored.
- SHIFT:
  - Bit index counts WIDTH-1 down to 0, one per cycle.
  - frame_last=1 on index 0.
  - After index 0, if frames remain:
    - GAP>0: go to GAP for exactly GAP cycles, then SHIFT restarting at WIDTH-1.
    - GAP=0: the next cycle carries pattern[WIDTH-1] with dout_valid held high.
  - After index 0 of the final frame: go to IDLE with done=1 for one cycle and busy=0 in that same cycle.
- start or load while busy: ignored. No effect on the current run or the pattern register.
- start during the done cycle: accepted (state is IDLE).
- abort in SHIFT or GAP:
  - Next edge gives IDLE with busy, dout_valid, dout and frame_last = 0.
  - No done pulse. Pattern register is kept.
  - abort in IDLE has no effect.
- abort + start in the same cycle: abort wins. No transmission starts.
- Total busy cycles per run: N·WIDTH + (N−1)·GAP, where N = frames.
- The frame counter is CNT_W bits. repeat_n = 2^CNT_W−1 must transmit exactly that many frames (no wrap).

Test Plan:
1. Reset, then start with repeat_n=1 → dout 1,0,1,1,0,0,1,0 on cycles 1–8 after start. dout_valid=1 for exactly those 8 cycles, frame_last on cycle 8, done=1 on cycle 9 only, busy high cycles 1–8.
2. load pattern_in=8'hA5, then start with repeat_n=2 (GAP=2) → bits 1010_0101, then 2 cycles of dout_valid=0, then 1010_0101 again. busy high for 18 cycles, frame_last pulses twice, a single done.
3. start with repeat_n=0 → exactly one 8-bit frame and one done. A second start issued during the done cycle → a new frame begins the following cycle.
4. While busy, pulse start and load (pattern_in=8'hFF) → current run unchanged. Next run still sends the previous pattern.
5. abort on the 3rd bit of the frame → the following cycle has dout_valid=0, busy=0 and no done. A later start sends a full correct frame.
6. reset asserted mid-frame after load 8'hA5 → all outputs 0 at the next edge. The next start sends 1011_0010 (DEFAULT_PATTERN).
